// File: rtl/pmu_pkg.sv
// -----------------------------------------------------------------------------
// pmu_pkg
// Shared definitions for the PMU sequencing logic: clock-source codes, the
// scheduler FSM state encoding, change_vector field layout, the power-on
// shadow value and small helpers that operate on the packed shadow word.
// The source codes and field positions are the same ones power_manager
// decodes, so that block can import this package instead of using local
// defines.
//
// Shadow word layout (9 bits): [8:6] clock1, [5:3] clock2, [2:0] clock3.
// Domain mask layout (3 bits): bit2 clock1, bit1 clock2, bit0 clock3, so
// mask bit k always selects shadow field [3k+2:3k].
// -----------------------------------------------------------------------------
package pmu_pkg;

    // Clock-source codes understood by power_manager
    localparam logic [2:0] SET_PLL = 3'd0;
    localparam logic [2:0] SET_CLK = 3'd1;
    localparam logic [2:0] SET_FR1 = 3'd2;
    localparam logic [2:0] SET_FR2 = 3'd3;
    localparam logic [2:0] SET_FR3 = 3'd4;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_ACK    = 3'd4
    } pmu_state_e;

    // change_vector field positions
    localparam int CV_MASK_MSB = 7;
    localparam int CV_MASK_LSB = 5;
    localparam int CV_MODE_MSB = 2;
    localparam int CV_MODE_LSB = 0;

    // Clock settings power_manager comes out of reset with
    localparam logic [8:0] CUR_MODE_POR = {SET_CLK, SET_FR2, SET_PLL};

    // Pack a domain mask and source code into a change_vector word
    function automatic logic [7:0] build_cv(input logic [2:0] mask, input logic [2:0] mode);
        return {mask, 2'b00, mode};
    endfunction

    // True when every clock selected by mask already runs at mode
    function automatic logic shadow_hit(input logic [8:0] cur, input logic [2:0] mask,
                                        input logic [2:0] mode);
        logic hit;
        hit = 1'b1;
        for (int k = 0; k < 3; k++) begin
            hit = hit & (~mask[k] | (cur[k*3 +: 3] == mode));
        end
        return hit;
    endfunction

    // Shadow word after mode has been applied to every masked clock
    function automatic logic [8:0] shadow_apply(input logic [8:0] cur, input logic [2:0] mask,
                                                input logic [2:0] mode);
        logic [8:0] res;
        res = cur;
        for (int k = 0; k < 3; k++) begin
            res[k*3 +: 3] = mask[k] ? mode : cur[k*3 +: 3];
        end
        return res;
    endfunction

endpackage

// File: rtl/pmu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// pmu_rr_arbiter
// Combinational round-robin arbiter. The search starts one position after
// the last granted index and wraps from NUM_REQ-1 back to 0, so the last
// winner has the lowest priority on the next round.
//
// Ports:
//   req  in  NUM_REQ : request vector
//   ptr  in  IW      : index granted last time
//   gnt  out NUM_REQ : one-hot grant (all zero when req == 0)
//   idx  out IW      : index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module pmu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);

    // Walk the requesters in priority order; the first hit wins
    always_comb begin
        logic          found;
        logic          hit;
        logic [IW-1:0] cand;
        found = 1'b0;
        hit   = 1'b0;
        cand  = '0;
        gnt   = '0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand  = IW'((int'(ptr) + i) % NUM_REQ);
            hit   = ~found & req[cand];
            found = found | hit;
            idx   = hit ? cand : idx;
            gnt   = gnt | (hit ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << cand) : '0);
        end
    end

endmodule

// File: rtl/pmu_scheduler.sv
// -----------------------------------------------------------------------------
// pmu_scheduler
// Round-robin sequencer in front of power_manager. Each requester asks for a
// clock source on a subset of the three generated clocks; one request is
// served at a time: the command is checked against the shadow of the current
// clock settings, issued as a single change strobe if needed, held for a
// settle window and then acknowledged. Redundant requests are acknowledged
// without touching the PMU; invalid source codes are acknowledged with err.
//
// Ports:
//   clk            in  1          system clock (shared with power_manager)
//   reset_n        in  1          asynchronous active-low reset
//   req            in  NUM_REQ    level requests, held until ack
//   req_domain     in  3*NUM_REQ  per-requester clock mask
//   req_mode       in  3*NUM_REQ  per-requester source code
//   ack            out NUM_REQ    one-cycle completion pulse
//   err            out 1          one-cycle reject pulse, coincident with ack
//   busy           out 1          high outside IDLE
//   change         out 1          one-cycle strobe to power_manager
//   change_vector  out 8          {mask, 2'b00, mode}, held between strobes
//   cur_mode       out 9          shadow settings {clock1, clock2, clock3}
//
// Optional feature: define PMU_IDLE_SLEEP_EN to add an idle counter that,
// after IDLE_TIMEOUT request-free IDLE cycles, downclocks clock2/clock3 to
// SET_FR1 through an internal command that generates no ack.
// -----------------------------------------------------------------------------
module pmu_scheduler
    import pmu_pkg::*;
#(
    parameter int          NUM_REQ       = 4,
    parameter int          SETTLE_CYCLES = 16,
    parameter logic [23:0] IDLE_TIMEOUT  = 24'd12_000_000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_domain,
    input  logic [3*NUM_REQ-1:0]   req_mode,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   err,
    output logic                   busy,
    output logic                   change,
    output logic [7:0]             change_vector,
    output logic [8:0]             cur_mode
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

    pmu_state_e          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [2:0]          mask_q, mask_d;
    logic [2:0]          mode_q, mode_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                change_q, change_d;
    logic [7:0]          cv_q, cv_d;
    logic [8:0]          cur_q, cur_d;

`ifdef PMU_IDLE_SLEEP_EN
    logic [23:0]         idle_cnt_q, idle_cnt_d;
    logic                armed_q, armed_d;
    logic                auto_q, auto_d;
`endif

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_valid;
    logic [2:0]          dom_a [NUM_REQ];
    logic [2:0]          mode_a [NUM_REQ];
    logic [NUM_REQ-1:0]  ack_onehot;

    pmu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign arb_valid  = |arb_gnt;
    assign ack_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;

    // Unpack the flat per-requester mask/mode buses for indexed selection
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            dom_a[i]  = req_domain[i*3 +: 3];
            mode_a[i] = req_mode[i*3 +: 3];
        end
    end

    // Next-state and next-output logic; outputs are set on the transition
    // into the state that owns them so they appear registered in that state
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        mask_d   = mask_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        err_d    = 1'b0;
        change_d = 1'b0;
        cv_d     = cv_q;
        cur_d    = cur_q;
`ifdef PMU_IDLE_SLEEP_EN
        armed_d  = armed_q;
        auto_d   = auto_q;
        // Count request-free IDLE cycles, saturating at the timeout
        if ((state_q == ST_IDLE) && (req == '0) && armed_q) begin
            idle_cnt_d = (idle_cnt_q == IDLE_TIMEOUT) ? idle_cnt_q : idle_cnt_q + 24'd1;
        end else begin
            idle_cnt_d = 24'd0;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    idx_d   = arb_idx;
                    mask_d  = dom_a[arb_idx];
                    mode_d  = mode_a[arb_idx];
                    state_d = ST_GRANT;
                end
`ifdef PMU_IDLE_SLEEP_EN
                else if (armed_q && (idle_cnt_q == IDLE_TIMEOUT)) begin
                    // Internal downclock of clock2/clock3; skips GRANT
                    auto_d     = 1'b1;
                    armed_d    = 1'b0;
                    idle_cnt_d = 24'd0;
                    mask_d     = 3'b011;
                    mode_d     = SET_FR1;
                    change_d   = 1'b1;
                    cv_d       = build_cv(3'b011, SET_FR1);
                    cur_d      = shadow_apply(cur_q, 3'b011, SET_FR1);
                    cnt_d      = SETTLE_LOAD;
                    state_d    = ST_ISSUE;
                end
`endif
                else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GRANT: begin
                if (mode_q > SET_FR3) begin
                    ack_d   = ack_onehot;
                    err_d   = 1'b1;
                    state_d = ST_ACK;
                end else if ((mask_q == 3'b000) || shadow_hit(cur_q, mask_q, mode_q)) begin
                    // Nothing to change: acknowledge without a PMU command
                    ack_d   = ack_onehot;
                    state_d = ST_ACK;
                end else begin
                    change_d = 1'b1;
                    cv_d     = build_cv(mask_q, mode_q);
                    cur_d    = shadow_apply(cur_q, mask_q, mode_q);
                    cnt_d    = SETTLE_LOAD;
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                state_d = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (cnt_q == 16'd0) begin
`ifdef PMU_IDLE_SLEEP_EN
                    ack_d = auto_q ? '0 : ack_onehot;
`else
                    ack_d = ack_onehot;
`endif
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end

            ST_ACK: begin
`ifdef PMU_IDLE_SLEEP_EN
                // The internal command neither moves the pointer nor re-arms
                if (!auto_q) begin
                    ptr_d   = idx_q;
                    armed_d = 1'b1;
                end else begin
                    auto_d  = 1'b0;
                end
`else
                ptr_d = idx_q;
`endif
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            ptr_q    <= IW'(NUM_REQ - 1);
            mask_q   <= 3'b000;
            mode_q   <= 3'b000;
            cnt_q    <= 16'd0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            change_q <= 1'b0;
            cv_q     <= 8'h00;
            cur_q    <= CUR_MODE_POR;
`ifdef PMU_IDLE_SLEEP_EN
            idle_cnt_q <= 24'd0;
            armed_q    <= 1'b1;
            auto_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            change_q <= change_d;
            cv_q     <= cv_d;
            cur_q    <= cur_d;
`ifdef PMU_IDLE_SLEEP_EN
            idle_cnt_q <= idle_cnt_d;
            armed_q    <= armed_d;
            auto_q     <= auto_d;
`endif
        end
    end

    assign ack           = ack_q;
    assign err           = err_q;
    assign busy          = busy_q;
    assign change        = change_q;
    assign change_vector = cv_q;
    assign cur_mode      = cur_q;

endmodule

// File: tb/tb_pmu_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pmu_scheduler
// Self-checking bench for pmu_scheduler (NUM_REQ=4, SETTLE_CYCLES=4).
// Each round raises a set of requests at once while the scheduler is idle.
// A transaction-level model predicts, from the arbitration order and the
// clock shadow, the absolute cycle and value of every change strobe and every
// ack/err pulse; the observed event streams are compared against it.
// -----------------------------------------------------------------------------
module tb_pmu_scheduler;

    localparam int N = 4;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [3*N-1:0] req_domain;
    logic [3*N-1:0] req_mode;
    logic [N-1:0]   ack;
    logic           err;
    logic           busy;
    logic           change;
    logic [7:0]     change_vector;
    logic [8:0]     cur_mode;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    // Requester settings and model state
    int r_dom [N];
    int r_mode [N];
    int m_ptr;
    int sh [3];          // sh[0] clock1, sh[1] clock2, sh[2] clock3
    int last_vec;

    int exp_chg_cyc[$], exp_chg_vec[$], exp_ack_cyc[$], exp_ack_vec[$], exp_err[$];
    int obs_chg_cyc[$], obs_chg_vec[$], obs_ack_cyc[$], obs_ack_vec[$], obs_err[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pmu_scheduler #(
        .NUM_REQ       (N),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .req_domain    (req_domain),
        .req_mode      (req_mode),
        .ack           (ack),
        .err           (err),
        .busy          (busy),
        .change        (change),
        .change_vector (change_vector),
        .cur_mode      (cur_mode)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            req_domain[i*3 +: 3] = 3'(r_dom[i]);
            req_mode[i*3 +: 3]   = 3'(r_mode[i]);
        end
    endtask

    task automatic model_reset();
        m_ptr    = N - 1;
        sh[0]    = 1;
        sh[1]    = 3;
        sh[2]    = 0;
        last_vec = 0;
    endtask

    function automatic int model_cur();
        return sh[0] * 64 + sh[1] * 8 + sh[2];
    endfunction

    task automatic clear_queues();
        exp_chg_cyc.delete(); exp_chg_vec.delete();
        exp_ack_cyc.delete(); exp_ack_vec.delete(); exp_err.delete();
        obs_chg_cyc.delete(); obs_chg_vec.delete();
        obs_ack_cyc.delete(); obs_ack_vec.delete(); obs_err.delete();
    endtask

    // One cycle: sample on the falling edge, record events, requesters drop on ack
    task automatic step();
        @(negedge clk);
        if (change === 1'b1) begin
            obs_chg_cyc.push_back(cyc);
            obs_chg_vec.push_back(int'(change_vector));
        end
        if ((ack !== '0) || (err !== 1'b0)) begin
            obs_ack_cyc.push_back(cyc);
            obs_ack_vec.push_back(int'(ack));
            obs_err.push_back(int'(err));
        end
        req = req & ~ack;
    endtask

    // Serve all requests in reqs starting from IDLE in cycle c0
    task automatic predict(input logic [N-1:0] reqs, input int c0, output int t_end);
        logic [N-1:0] pend;
        int t, w, msk, md;
        bit same;
        pend  = reqs;
        t     = c0;
        t_end = c0;
        while (pend != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (w < 0 && pend[j]) w = j;
            end
            msk = r_dom[w];
            md  = r_mode[w];
            same = 1'b1;
            for (int c = 0; c < 3; c++) begin
                if (((msk >> (2 - c)) & 1) == 1 && sh[c] != md) same = 1'b0;
            end
            if (md > 4 || msk == 0 || same) begin
                exp_ack_cyc.push_back(t + 2);
                exp_ack_vec.push_back(1 << w);
                exp_err.push_back((md > 4) ? 1 : 0);
                t_end = t + 2;
                t     = t + 3;
            end else begin
                exp_chg_cyc.push_back(t + 2);
                exp_chg_vec.push_back(msk * 32 + md);
                last_vec = msk * 32 + md;
                for (int c = 0; c < 3; c++) begin
                    if (((msk >> (2 - c)) & 1) == 1) sh[c] = md;
                end
                exp_ack_cyc.push_back(t + S + 3);
                exp_ack_vec.push_back(1 << w);
                exp_err.push_back(0);
                t_end = t + S + 3;
                t     = t + S + 4;
            end
            m_ptr   = w;
            pend[w] = 1'b0;
        end
    endtask

    task automatic compare_round(input string name);
        int n;
        check_eq({name, " n_change"}, obs_chg_cyc.size(), exp_chg_cyc.size());
        n = (obs_chg_cyc.size() < exp_chg_cyc.size()) ? obs_chg_cyc.size() : exp_chg_cyc.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s change_cyc[%0d]", name, i), obs_chg_cyc[i], exp_chg_cyc[i]);
            check_eq($sformatf("%s change_vec[%0d]", name, i), obs_chg_vec[i], exp_chg_vec[i]);
        end
        check_eq({name, " n_ack"}, obs_ack_cyc.size(), exp_ack_cyc.size());
        n = (obs_ack_cyc.size() < exp_ack_cyc.size()) ? obs_ack_cyc.size() : exp_ack_cyc.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s ack_cyc[%0d]", name, i), obs_ack_cyc[i], exp_ack_cyc[i]);
            check_eq($sformatf("%s ack_vec[%0d]", name, i), obs_ack_vec[i], exp_ack_vec[i]);
            check_eq($sformatf("%s err[%0d]", name, i), obs_err[i], exp_err[i]);
        end
        check_eq({name, " cur_mode"}, cur_mode, model_cur());
        check_eq({name, " change_vector_hold"}, change_vector, last_vec);
        check_eq({name, " busy_idle"}, busy, 0);
        clear_queues();
    endtask

    task automatic run_round(input string name, input logic [N-1:0] reqs);
        int c0, t_end;
        apply_inputs();
        req = reqs;
        c0  = cyc;
        predict(reqs, c0, t_end);
        while (cyc < t_end + 2) step();
        compare_round(name);
    endtask

    initial begin
        reset_n    = 1'b0;
        req        = '0;
        req_domain = '0;
        req_mode   = '0;
        for (int i = 0; i < N; i++) begin
            r_dom[i]  = 0;
            r_mode[i] = 0;
        end
        model_reset();
        clear_queues();
        repeat (3) @(negedge clk);

        check_eq("rst ack", ack, 0);
        check_eq("rst err", err, 0);
        check_eq("rst busy", busy, 0);
        check_eq("rst change", change, 0);
        check_eq("rst change_vector", change_vector, 8'h00);
        check_eq("rst cur_mode", cur_mode, 9'o130);
        reset_n = 1'b1;

        // Redundant request: clock1 already SET_CLK
        r_dom[1] = 3'b100; r_mode[1] = 1;
        run_round("skip", 4'b0010);
        // Invalid source code
        r_dom[2] = 3'b010; r_mode[2] = 6;
        run_round("reject", 4'b0100);
        // Real change on clock1: vector 8'h82
        r_dom[0] = 3'b100; r_mode[0] = 2;
        run_round("change", 4'b0001);
        // Empty mask
        r_dom[3] = 3'b000; r_mode[3] = 3;
        run_round("nomask", 4'b1000);
        // All four at once, each needing a PMU command
        r_dom[0] = 3'b001; r_mode[0] = 4;
        r_dom[1] = 3'b010; r_mode[1] = 0;
        r_dom[2] = 3'b100; r_mode[2] = 3;
        r_dom[3] = 3'b111; r_mode[3] = 1;
        run_round("all4", 4'b1111);

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++) begin
                r_dom[i]  = int'($urandom_range(0, 7));
                r_mode[i] = int'($urandom_range(0, 6));
            end
            run_round($sformatf("rnd%0d", r), 4'($urandom_range(1, 15)));
        end

        // Reset in the middle of SETTLE with the request held throughout
        r_dom[0]  = 3'b010;
        r_mode[0] = (sh[1] == 2) ? 4 : 2;
        apply_inputs();
        req = 4'b0001;
        repeat (4) step();
        check_eq("pre_reset n_change", obs_chg_cyc.size(), 1);
        check_eq("pre_reset n_ack", obs_ack_cyc.size(), 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mid_reset busy", busy, 0);
        check_eq("mid_reset cur_mode", cur_mode, 9'o130);
        check_eq("mid_reset ack", ack, 0);
        check_eq("mid_reset change", change, 0);
        check_eq("mid_reset change_vector", change_vector, 8'h00);
        model_reset();
        clear_queues();
        repeat (3) step();
        check_eq("in_reset n_ack", obs_ack_cyc.size(), 0);
        check_eq("in_reset n_change", obs_chg_cyc.size(), 0);
        clear_queues();
        reset_n = 1'b1;
        run_round("restart", 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
